// File: rtl/mmio_periph_bus_if.sv
// CPU load/store bus toward the MMIO peripheral block.
// The master drives strobes, address and write data; the slave returns read data combinationally.
interface mmio_periph_bus_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_periph_bus.sv
// MMIO peripherals in the 0x4xxxxxxx window: reloadable timer with irq, systick,
// LED/7-segment output registers and a synchronised switch input.
module mmio_periph_bus #(
  parameter int unsigned LED_WIDTH  = 8,
  parameter int unsigned SW_WIDTH   = 8,
  parameter int unsigned DIGI_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_periph_bus_if.slave      bus,
  input  logic [SW_WIDTH-1:0]   switch,
  output logic [LED_WIDTH-1:0]  led,
  output logic [DIGI_WIDTH-1:0] digi,
  output logic                  irqout
);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_SWITCH  = 3'd4,
    REG_DIGI    = 3'd5,
    REG_SYSTICK = 3'd6,
    REG_NONE    = 3'd7
  } reg_sel_e;

  logic [31:0]           r_th;
  logic [31:0]           r_tl;
  logic [2:0]            r_tcon;
  logic [LED_WIDTH-1:0]  r_led;
  logic [DIGI_WIDTH-1:0] r_digi;
  logic [31:0]           r_systick;
  logic [SW_WIDTH-1:0]   r_sw_meta;
  logic [SW_WIDTH-1:0]   r_sw_sync;

  reg_sel_e    w_sel;
  logic        w_page;
  logic        w_ovf;
  logic        w_ovf_set;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Exact word match: 0x40000000..0x4000001F, index 7 of that window is unmapped.
  assign w_page    = (bus.addr[31:5] == 27'h2000000);
  assign w_sel     = w_page ? reg_sel_e'(bus.addr[4:2]) : REG_NONE;
  assign w_ovf     = r_tcon[0] && (r_tl == '1);
  assign w_ovf_set = w_ovf && r_tcon[1];
  assign w_unused  = ^bus.addr[1:0];

  always_comb begin
    w_rdata = '0;
    if (bus.rd) begin
      case (w_sel)
        REG_TH:      w_rdata = r_th;
        REG_TL:      w_rdata = r_tl;
        REG_TCON:    w_rdata = 32'(r_tcon);
        REG_LED:     w_rdata = 32'(r_led);
        REG_SWITCH:  w_rdata = 32'(r_sw_sync);
        REG_DIGI:    w_rdata = 32'(r_digi);
        REG_SYSTICK: w_rdata = r_systick;
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_led     <= '0;
      r_digi    <= '0;
      r_systick <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      r_systick <= r_systick + 32'd1;

      // Reload always uses the TH value held before this edge.
      if (bus.wr && w_sel == REG_TH) r_th <= bus.wdata;

      if (bus.wr && w_sel == REG_TL)  r_tl <= bus.wdata;
      else if (w_ovf)                 r_tl <= r_th;
      else if (r_tcon[0])             r_tl <= r_tl + 32'd1;

      // Status can only be cleared by software, never set; a concurrent overflow wins.
      if (bus.wr && w_sel == REG_TCON)
        r_tcon <= {w_ovf_set | (r_tcon[2] & bus.wdata[2]), bus.wdata[1:0]};
      else
        r_tcon[2] <= r_tcon[2] | w_ovf_set;

      if (bus.wr && w_sel == REG_LED)  r_led  <= bus.wdata[LED_WIDTH-1:0];
      if (bus.wr && w_sel == REG_DIGI) r_digi <= bus.wdata[DIGI_WIDTH-1:0];
    end
  end

  assign led    = r_led;
  assign digi   = r_digi;
  assign irqout = r_tcon[1] & r_tcon[2];

endmodule

// File: tb/tb_mmio_periph_bus.sv
// Directed scoreboard bench for mmio_periph_bus: reset, timer reload/irq,
// status-clear race, write priority, decode and switch synchroniser.
module tb_mmio_periph_bus;
  localparam logic [31:0] A_TH   = 32'h40000000;
  localparam logic [31:0] A_TL   = 32'h40000004;
  localparam logic [31:0] A_TCON = 32'h40000008;
  localparam logic [31:0] A_LED  = 32'h4000000C;
  localparam logic [31:0] A_SW   = 32'h40000010;
  localparam logic [31:0] A_DIGI = 32'h40000014;
  localparam logic [31:0] A_SYS  = 32'h40000018;

  logic        clk;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;
  logic [31:0] tb_tick;

  int unsigned n_eval;
  int unsigned n_fail;
  logic [31:0] sb[$];

  mmio_periph_bus_if bus ();

  mmio_periph_bus #(
    .LED_WIDTH (8),
    .SW_WIDTH  (8),
    .DIGI_WIDTH(12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .switch(switch),
    .led   (led),
    .digi  (digi),
    .irqout(irqout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference systick: cycles since the last reset edge.
  always @(posedge clk) tb_tick <= reset ? 32'd0 : tb_tick + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_eval++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed %h, no expected value queued", tag, obs);
      return;
    end
    exp = sb.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic r, input logic [31:0] exp);
    bus.addr = a;
    bus.rd   = r;
    sb.push_back(exp);
    #1;
    chk(tag, bus.rdata);
    bus.rd = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb.push_back(exp);
    chk(tag, obs);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.rd    = 1'b0;
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.wr = 1'b0;
  endtask

  initial begin
    n_eval    = 0;
    n_fail    = 0;
    reset     = 1'b1;
    switch    = 8'h00;
    bus.rd    = 1'b0;
    bus.wr    = 1'b1;
    bus.addr  = A_LED;
    bus.wdata = 32'hFF;
    repeat (2) step();
    bus.wr = 1'b0;

    // Reset beats a concurrent LED write
    out_chk("rst_led", 32'(led), 32'h0);
    out_chk("rst_irq", 32'(irqout), 32'h0);
    out_chk("rst_digi", 32'(digi), 32'h0);
    for (int unsigned i = 0; i < 7; i++)
      rd_chk("rst_reg", A_TH + 32'(4 * i), 1'b1, 32'h0);
    reset = 1'b0;

    do_write(A_LED, 32'hA5);
    out_chk("led_out", 32'(led), 32'hA5);
    rd_chk("led_rd", A_LED, 1'b1, 32'h000000A5);

    rd_chk("systick_a", A_SYS, 1'b1, tb_tick);
    step();
    rd_chk("systick_b", A_SYS, 1'b1, tb_tick);

    // Timer overflow and reload
    do_write(A_TH, 32'hFFFFFFFC);
    do_write(A_TL, 32'hFFFFFFFE);
    do_write(A_TCON, 32'h3);
    rd_chk("tl_start", A_TL, 1'b1, 32'hFFFFFFFE);
    rd_chk("tcon_start", A_TCON, 1'b1, 32'h3);
    step();
    rd_chk("tl_max", A_TL, 1'b1, 32'hFFFFFFFF);
    out_chk("irq_pre_ovf", 32'(irqout), 32'h0);
    step();
    rd_chk("tl_reload", A_TL, 1'b1, 32'hFFFFFFFC);
    rd_chk("tcon_ovf", A_TCON, 1'b1, 32'h7);
    out_chk("irq_ovf", 32'(irqout), 32'h1);
    step();
    rd_chk("tl_fd", A_TL, 1'b1, 32'hFFFFFFFD);
    step();
    rd_chk("tl_fe", A_TL, 1'b1, 32'hFFFFFFFE);
    step();
    rd_chk("tl_ff", A_TL, 1'b1, 32'hFFFFFFFF);

    // Clear in the overflow cycle must not lose the status
    do_write(A_TCON, 32'h3);
    rd_chk("tl_reload2", A_TL, 1'b1, 32'hFFFFFFFC);
    rd_chk("tcon_race", A_TCON, 1'b1, 32'h7);
    out_chk("irq_race", 32'(irqout), 32'h1);
    do_write(A_TCON, 32'h3);
    rd_chk("tcon_clear", A_TCON, 1'b1, 32'h3);
    out_chk("irq_clear", 32'(irqout), 32'h0);

    // Overflow with irq enable off
    do_write(A_TCON, 32'h1);
    rd_chk("tl_noirq_fe", A_TL, 1'b1, 32'hFFFFFFFE);
    repeat (2) step();
    rd_chk("tl_noirq_reload", A_TL, 1'b1, 32'hFFFFFFFC);
    rd_chk("tcon_noirq", A_TCON, 1'b1, 32'h1);
    out_chk("irq_noirq", 32'(irqout), 32'h0);

    // Disabled timer holds
    do_write(A_TCON, 32'h0);
    rd_chk("tl_disable", A_TL, 1'b1, 32'hFFFFFFFD);
    repeat (10) step();
    rd_chk("tl_hold", A_TL, 1'b1, 32'hFFFFFFFD);

    // CPU write to TL beats the increment
    do_write(A_TCON, 32'h1);
    do_write(A_TL, 32'h10);
    rd_chk("tl_wr_wins", A_TL, 1'b1, 32'h10);
    step();
    rd_chk("tl_after_wr", A_TL, 1'b1, 32'h11);

    // Decode
    rd_chk("unmapped_20", 32'h40000020, 1'b1, 32'h0);
    rd_chk("unmapped_low", 32'h00000010, 1'b1, 32'h0);
    rd_chk("rd_low", A_LED, 1'b0, 32'h0);
    do_write(A_SW, 32'hFF);
    rd_chk("sw_ro", A_SW, 1'b1, 32'h0);
    out_chk("led_kept", 32'(led), 32'hA5);

    // Switch synchroniser: two edges of latency
    switch = 8'h5A;
    rd_chk("sw_0", A_SW, 1'b1, 32'h0);
    step();
    rd_chk("sw_1", A_SW, 1'b1, 32'h0);
    step();
    rd_chk("sw_2", A_SW, 1'b1, 32'h5A);

    do_write(A_DIGI, 32'hFFFFFABC);
    out_chk("digi_out", 32'(digi), 32'hABC);
    rd_chk("digi_rd", A_DIGI, 1'b1, 32'h00000ABC);

    // Reset mid-count
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_chk("mid_rst_tl", A_TL, 1'b1, 32'h0);
    rd_chk("mid_rst_th", A_TH, 1'b1, 32'h0);
    rd_chk("mid_rst_tcon", A_TCON, 1'b1, 32'h0);
    rd_chk("mid_rst_sys", A_SYS, 1'b1, tb_tick);
    out_chk("mid_rst_led", 32'(led), 32'h0);
    out_chk("mid_rst_digi", 32'(digi), 32'h0);
    step();
    rd_chk("post_rst_tl", A_TL, 1'b1, 32'h0);
    rd_chk("post_rst_sw", A_SW, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
